// File: rtl/mac_pkg.sv
// Shared types and sizing for the iterative shift-and-add MAC sequencer.
package mac_pkg;

    localparam int MAC_OP_W  = 16;
    localparam int MAC_ACC_W = 32;
    localparam int CNT_W     = $clog2(MAC_OP_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } mac_state_t;

endpackage

// File: rtl/mac_sequencer_adder.sv
// Plain combinational ripple adder shared by the MAC datapath; carry out flags wrap.
module mac_sequencer_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mac_sequencer.sv
// Iterative multiply-accumulate controller: one partial product per cycle, one shared adder.
// Optional MAC_SAT_EN: accumulator saturates to all-ones on overflow instead of wrapping.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int OP_W  = MAC_OP_W,
    parameter int ACC_W = MAC_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);

    mac_state_t       state;
    mac_state_t       state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] mcand;
    logic [OP_W-1:0]  mplier;
    logic [CNT_W-1:0] count;
    logic             clr_q;

    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_b;
    logic [ACC_W-1:0] add_sum;
    logic             add_cout;
    logic [ACC_W-1:0] base;
    logic             last_iter;

    assign base      = clr_q ? '0 : acc;
    assign last_iter = (count == CNT_W'(OP_W - 1));
    assign acc_out   = acc;

    // The adder belongs to whichever path the state selects; idle states park it at zero.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            MUL: begin
                add_a = prod;
                add_b = mcand;
            end
            ACC: begin
                add_a = base;
                add_b = prod;
            end
            default: ;
        endcase
    end

    mac_sequencer_adder #(
        .WIDTH(ACC_W)
    ) u_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .cout(add_cout)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MUL;
            end
            MUL: begin
                if (last_iter) state_nxt = ACC;
            end
            ACC: begin
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Carry out of the ACC-cycle addition is exactly the "sum wrapped below base" case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            clr_q  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= ACC_W'(in_a);
                        mplier <= in_b;
                        clr_q  <= in_clr;
                        prod   <= '0;
                        count  <= '0;
                    end
                end
                MUL: begin
                    if (mplier[0]) prod <= add_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                end
                ACC: begin
`ifdef MAC_SAT_EN
                    acc <= add_cout ? '1 : add_sum;
`else
                    acc <= add_sum;
`endif
                    ovf <= (clr_q ? 1'b0 : ovf) | add_cout;
                end
                default: ;
            endcase
        end
    end

endmodule
